// File: rtl/serial_tx.sv
// Serial transmitter: frames a parallel payload as start, LSB-first data,
// optional even parity and stop bits on a registered, idle-high line.
module serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shifted;
  logic              parity_q, parity_d;
  logic              tx_out_q, tx_out_d;
  logic              done_q, done_d;
  logic              armed_q;
  logic              bit_end;

  // armed_q keeps tx_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_out_q <= 1'b1;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_out_q <= tx_out_d;
      done_q   <= done_d;
      armed_q  <= 1'b1;
    end
  end

  assign tx_ready = armed_q && (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_out   = tx_out_q;
  assign tx_done  = done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_out_d = tx_out_q;
    done_d   = 1'b0;
    shifted  = shift_q >> 1;
    bit_end  = (cnt_q == CNT_LAST);

    // tx_out_d is the value of the bit being entered, so the line changes on
    // the same edge the FSM crosses a bit boundary.
    unique case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        cnt_d    = '0;
        idx_d    = '0;
        if (tx_valid && tx_ready) begin
          state_d  = START;
          tx_out_d = 1'b0;
          shift_d  = tx_data;
          parity_d = ^tx_data;
        end
      end
      START: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d  = DATA;
          tx_out_d = shift_q[0];
        end
      end
      DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d  = PARITY;
              tx_out_d = parity_q;
            end else begin
              state_d  = STOP;
              tx_out_d = 1'b1;
            end
          end else begin
            idx_d    = idx_q + 1'b1;
            shift_d  = shifted;
            tx_out_d = shifted[0];
          end
        end
      end
      PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d  = STOP;
          tx_out_d = 1'b1;
        end
      end
      STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          tx_out_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: three lanes (no parity, parity, one-cycle
// bits) with a per-cycle frame monitor checking line, busy, ready and done.
module tb_serial_tx;

  typedef struct {
    logic [7:0] d;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_v [3];
  logic [2:0] valid_v;
  logic [2:0] ready_v;
  logic [2:0] out_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;

  exp_t sb_q [3][$];
  int   vector_count = 0;
  int   miscompare_count = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int idx, input int par);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && par != 0) return ^d;
    return 1'b1;
  endfunction

  function automatic int lane_cpb(input int g);
    return (g == 2) ? 1 : 4;
  endfunction

  function automatic int lane_len(input int g);
    return (10 + ((g == 0) ? 0 : 1)) * lane_cpb(g);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int CPB = (g == 2) ? 1 : 4;
    localparam int PAR = (g == 0) ? 0 : 1;
    localparam int LEN = (10 + PAR) * CPB;

    serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(PAR)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .tx_data (data_v[g]),
      .tx_valid(valid_v[g]),
      .tx_ready(ready_v[g]),
      .tx_out  (out_v[g]),
      .tx_busy (busy_v[g]),
      .tx_done (done_v[g])
    );

    int   phase = 0;
    int   k = 0;
    int   gap_cnt = 0;
    int   since_rst = 0;
    exp_t cur;

    // Phase 0 idle, 1 tracking an expected frame, 2 riding out an unexpected one.
    always @(negedge clk) begin
      if (reset) begin
        checkOutput($sformatf("u%0d_rst_out", g), out_v[g], 1);
        checkOutput($sformatf("u%0d_rst_ready", g), ready_v[g], 0);
        checkOutput($sformatf("u%0d_rst_busy", g), busy_v[g], 0);
        checkOutput($sformatf("u%0d_rst_done", g), done_v[g], 0);
        phase = 0;
        since_rst = 0;
        gap_cnt = 0;
      end else begin
        if (phase == 0 && busy_v[g]) begin
          checkOutput($sformatf("u%0d_frame_expected", g), busy_v[g], sb_q[g].size() != 0);
          if (sb_q[g].size() != 0) begin
            cur = sb_q[g].pop_front();
            if (cur.gap >= 0)
              checkOutput($sformatf("u%0d_idle_gap", g), gap_cnt, cur.gap);
            phase = 1;
            k = 0;
          end else begin
            phase = 2;
          end
        end
        if (phase == 1) begin
          if (k < LEN) begin
            checkOutput($sformatf("u%0d_d%02h_bit%0d_c%0d", g, cur.d, k / CPB, k),
                        out_v[g], exp_bit(cur.d, k / CPB, PAR));
            checkOutput($sformatf("u%0d_busy_c%0d", g, k), busy_v[g], 1);
            checkOutput($sformatf("u%0d_ready_c%0d", g, k), ready_v[g], 0);
            checkOutput($sformatf("u%0d_done_c%0d", g, k), done_v[g], 0);
            k++;
          end else begin
            checkOutput($sformatf("u%0d_done_pulse", g), done_v[g], 1);
            checkOutput($sformatf("u%0d_done_ready", g), ready_v[g], 1);
            checkOutput($sformatf("u%0d_done_busy", g), busy_v[g], 0);
            checkOutput($sformatf("u%0d_done_out", g), out_v[g], 1);
            phase = 0;
            gap_cnt = 1;
          end
        end else if (phase == 0) begin
          checkOutput($sformatf("u%0d_idle_out", g), out_v[g], 1);
          checkOutput($sformatf("u%0d_idle_done", g), done_v[g], 0);
          checkOutput($sformatf("u%0d_idle_ready", g), ready_v[g], since_rst > 0);
          gap_cnt++;
        end else if (!busy_v[g]) begin
          phase = 0;
        end
        since_rst++;
      end
    end
  end

  // Offers one payload in a known-idle lane; the next edge is the transfer.
  task automatic applyStimulus(input int g, input logic [7:0] d, input int gap,
                               input bit hold);
    exp_t e;
    @(posedge clk);
    #2;
    data_v[g]  = d;
    valid_v[g] = 1'b1;
    e.d = d;
    e.gap = gap;
    sb_q[g].push_back(e);
    @(posedge clk);
    #2;
    data_v[g] = ~d;
    if (!hold) valid_v[g] = 1'b0;
  endtask

  task automatic waitFrame(input int g);
    repeat (lane_len(g) + 3) @(posedge clk);
  endtask

  task automatic applyBackToBack(input int g, input logic [7:0] d1, input logic [7:0] d2);
    exp_t e;
    applyStimulus(g, d1, -1, 1'b1);
    data_v[g] = d2;
    e.d = d2;
    e.gap = 1;
    sb_q[g].push_back(e);
    repeat (lane_len(g) + 1) @(posedge clk);
    #2;
    valid_v[g] = 1'b0;
    data_v[g]  = ~d2;
    waitFrame(g);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    valid_v = '0;
    for (int i = 0; i < 3; i++) data_v[i] = 8'h00;

    $display("[TB] reset check");
    #1 reset = 1'b1;
    #1;
    checkOutput("async_rst_out", out_v, 3'b111);
    checkOutput("async_rst_ready", ready_v, 3'b000);
    checkOutput("async_rst_busy", busy_v, 3'b000);
    checkOutput("async_rst_done", done_v, 3'b000);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] single frame A5, no parity");
    applyStimulus(0, 8'hA5, -1, 1'b0);
    waitFrame(0);

    $display("[TB] parity frames 07 and 03");
    applyStimulus(1, 8'h07, -1, 1'b0);
    waitFrame(1);
    applyStimulus(1, 8'h03, -1, 1'b0);
    waitFrame(1);

    $display("[TB] back-to-back 00 then FF");
    applyBackToBack(0, 8'h00, 8'hFF);

    $display("[TB] reset abort during data bit 3");
    applyStimulus(0, 8'h81, -1, 1'b0);
    repeat (17) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_async_out", out_v[0], 1);
    checkOutput("abort_async_busy", busy_v[0], 0);
    checkOutput("abort_async_done", done_v[0], 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    applyStimulus(0, 8'h3C, -1, 1'b0);
    waitFrame(0);

    $display("[TB] mid-frame data toggling and valid pulses");
    applyStimulus(0, 8'h5A, -1, 1'b0);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #2;
      data_v[0]  = 8'($urandom);
      valid_v[0] = (c == 5 || c == 6 || c == 20);
    end
    valid_v[0] = 1'b0;
    waitFrame(0);

    $display("[TB] one-cycle bits with parity");
    applyStimulus(2, 8'hA5, -1, 1'b0);
    waitFrame(2);
    applyBackToBack(2, 8'h3C, 8'hC3);

    repeat (5) @(posedge clk);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("u%0d_sb_empty", i), sb_q[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
